// File: rtl/led_blink_top.sv
// rtl/led_blink_top.sv - iCESugar-UP5K green LED blink top
//
// A free-running cycle counter wraps every INTERVAL = CLK_HZ*TOGGLE_SEC
// cycles and flips the green-on flag on each wrap. This gives a square
// wave with a period of 2*TOGGLE_SEC seconds on the green LED.
//
// Ports:
//   clk    in   system clock; all state updates on the rising edge
//   rst    in   asynchronous active-high reset (tie low on the board)
//   LED_R  out  red LED, active-low, held off (1)
//   LED_G  out  green LED, active-low, blink output
//   LED_B  out  blue LED, active-low, held off (1)
module led_blink_top #(
    parameter int CLK_HZ     = 12000000,
    parameter int TOGGLE_SEC = 10
) (
    input  logic clk,
    input  logic rst,
    output logic LED_R,
    output logic LED_G,
    output logic LED_B
);

    // The product can exceed 32 bits, so it is formed in 64-bit arithmetic
    // and range-checked below.
    localparam longint INTERVAL = longint'(CLK_HZ) * longint'(TOGGLE_SEC);
    localparam int     CNT_W    = (INTERVAL <= 1) ? 1 : $clog2(INTERVAL);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INTERVAL - 1);

    if (CLK_HZ < 1 || TOGGLE_SEC < 1 || INTERVAL > 64'sh0000_0000_FFFF_FFFF) begin : g_param_check
        $error("led_blink_top: CLK_HZ and TOGGLE_SEC must be >= 1 and their product must fit in 32 bits");
    end

    // Initial values match the reset values so the board can run with rst
    // tied low and the LEDs never show X.
    logic [CNT_W-1:0] r_cnt  = '0;
    logic             r_g_on = 1'b0;

    // The wrap is decided by the comparison with CNT_MAX, not by natural
    // overflow. This keeps power-of-two intervals exact as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_g_on <= 1'b0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt  <= '0;
            r_g_on <= ~r_g_on;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign LED_G = ~r_g_on;
    assign LED_R = 1'b1;
    assign LED_B = 1'b1;

endmodule

// File: tb/tb_led_blink_top.sv
// tb/tb_led_blink_top.sv - directed self-checking bench for led_blink_top
module tb_led_blink_top;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;
    logic rst_d = 1'b0;
    logic r_a, g_a, b_a;
    logic r_b, g_b, b_b;
    logic r_c, g_c, b_c;
    logic r_d, g_d, b_d;

    // INTERVAL = 30
    led_blink_top #(.CLK_HZ(10), .TOGGLE_SEC(3)) dut_a (
        .clk(clk), .rst(rst_a), .LED_R(r_a), .LED_G(g_a), .LED_B(b_a));
    // INTERVAL = 1
    led_blink_top #(.CLK_HZ(1), .TOGGLE_SEC(1)) dut_b (
        .clk(clk), .rst(rst_b), .LED_R(r_b), .LED_G(g_b), .LED_B(b_b));
    // INTERVAL = 8
    led_blink_top #(.CLK_HZ(4), .TOGGLE_SEC(2)) dut_c (
        .clk(clk), .rst(rst_c), .LED_R(r_c), .LED_G(g_c), .LED_B(b_c));
    // default parameters, INTERVAL = 120000000
    led_blink_top dut_d (
        .clk(clk), .rst(rst_d), .LED_R(r_d), .LED_G(g_d), .LED_B(b_d));

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int   ntog;
        int   tog_edge [3];
        logic tog_val  [3];
        logic prev_a;

        ntog = 0;
        for (int i = 0; i < 3; i++) begin
            tog_edge[i] = 0;
            tog_val[i]  = 1'b1;
        end

        // Power-up state with reset never asserted
        #1;
        check("a_led_g_powerup", 32'(g_a), 32'd1);
        check("a_led_r_powerup", 32'(r_a), 32'd1);
        check("a_led_b_powerup", 32'(b_a), 32'd1);
        check("b_led_g_powerup", 32'(g_b), 32'd1);
        check("c_led_g_powerup", 32'(g_c), 32'd1);
        check("d_led_g_powerup", 32'(g_d), 32'd1);
        check("d_cnt_width", $bits(dut_d.r_cnt), 32'd27);
        prev_a = g_a;

        // Free run for 300 edges; the edge count n is the bench's own time base
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (g_a !== prev_a) begin
                if (ntog < 3) begin
                    tog_edge[ntog] = n;
                    tog_val[ntog]  = g_a;
                end
                ntog++;
                prev_a = g_a;
            end
            check("a_led_r", 32'(r_a), 32'd1);
            check("a_led_b", 32'(b_a), 32'd1);
            if (n <= 8)
                check("b_led_g_alt", 32'(g_b), (n % 2 == 0) ? 32'd1 : 32'd0);
            if (n <= 64) begin
                check("c_led_g", 32'(g_c), ((n / 8) % 2 == 0) ? 32'd1 : 32'd0);
                check("c_cnt_le7", 32'(dut_c.r_cnt <= 7), 32'd1);
            end
        end
        check("d_cnt_300", 32'(dut_d.r_cnt), 32'd300);
        check("d_led_g_300", 32'(g_d), 32'd1);
        check("a_toggle_count", 32'(ntog >= 3), 32'd1);
        check("a_toggle0_edge", 32'(tog_edge[0]), 32'd30);
        check("a_toggle1_edge", 32'(tog_edge[1]), 32'd60);
        check("a_toggle2_edge", 32'(tog_edge[2]), 32'd90);
        check("a_toggle0_val", 32'(tog_val[0]), 32'd0);
        check("a_toggle1_val", 32'(tog_val[1]), 32'd1);
        check("a_toggle2_val", 32'(tog_val[2]), 32'd0);

        // Reset mid-interval: edge 345 has cnt=15, and the toggle at edge 330 lit the LED
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("a_led_g_pre_rst", 32'(g_a), 32'd0);
        check("a_cnt_pre_rst", 32'(dut_a.r_cnt), 32'd15);
        #3 rst_a = 1'b1;
        #1;
        check("a_led_g_async_rst", 32'(g_a), 32'd1);
        check("a_cnt_async_rst", 32'(dut_a.r_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("a_led_g_held_rst", 32'(g_a), 32'd1);
        rst_a = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("a_led_g_after_rst", 32'(g_a), (k < 30) ? 32'd1 : ((k < 60) ? 32'd0 : 32'd1));
        end

        // Reset asserted on a terminal-count edge
        for (int k = 0; k < 29; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("a_cnt_terminal", 32'(dut_a.r_cnt), 32'd29);
        check("a_led_g_terminal", 32'(g_a), 32'd1);
        @(posedge clk);
        rst_a = 1'b1;
        #1;
        check("a_led_g_rst_on_tc", 32'(g_a), 32'd1);
        check("a_cnt_rst_on_tc", 32'(dut_a.r_cnt), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k >= 29)
                check("a_led_g_after_tc_rst", 32'(g_a), (k < 30) ? 32'd1 : 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
